// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, EX/MEM and MEM/WB forwarding taps,
// and the registered EX-side outputs plus stall and bubble counter.
//
// Signals (master = surrounding pipeline, slave = id_ex_stage):
//   flush            squash the instruction currently in ID
//   id_*             decoded instruction fields and register-file reads
//   exmem_*, memwb_* writeback taps used for operand forwarding
//   aluOp/srcA/srcB  operands and opcode delivered to the ALU
//   ex_*             registered control and store data for EX
//   stall            hold PC and IF/ID this cycle
//   bubble_count     saturating count of stall/flush bubbles
interface id_ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              id_valid;
    logic [3:0]        id_aluOp;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_regA;
    logic [DATA_W-1:0] id_regB;
    logic [DATA_W-1:0] id_imm;
    logic              id_useImm;
    logic              id_regWrite;
    logic              id_memRead;
    logic              id_memWrite;

    logic              exmem_regWrite;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_regWrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_data;

    logic [3:0]        aluOp;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regWrite;
    logic              ex_memRead;
    logic              ex_memWrite;
    logic [DATA_W-1:0] ex_storeData;
    logic              stall;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output flush, id_valid, id_aluOp, id_rs1, id_rs2, id_rd,
        output id_regA, id_regB, id_imm, id_useImm,
        output id_regWrite, id_memRead, id_memWrite,
        output exmem_regWrite, exmem_rd, exmem_result,
        output memwb_regWrite, memwb_rd, memwb_data,
        input  aluOp, srcA, srcB, ex_rd, ex_regWrite,
        input  ex_memRead, ex_memWrite, ex_storeData,
        input  stall, bubble_count
    );

    modport slave (
        input  flush, id_valid, id_aluOp, id_rs1, id_rs2, id_rd,
        input  id_regA, id_regB, id_imm, id_useImm,
        input  id_regWrite, id_memRead, id_memWrite,
        input  exmem_regWrite, exmem_rd, exmem_result,
        input  memwb_regWrite, memwb_rd, memwb_data,
        output aluOp, srcA, srcB, ex_rd, ex_regWrite,
        output ex_memRead, ex_memWrite, ex_storeData,
        output stall, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode fields, detects load-use
// hazards (bubble + stall), forwards operands from EX/MEM and MEM/WB.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    id_ex_stage_if slave (ID fields, forwarding taps, EX outputs)
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic [3:0]        aluOp;
        logic [REG_AW-1:0] rd;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
    } ctrl_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] regA;
        logic [DATA_W-1:0] regB;
        logic [DATA_W-1:0] imm;
        logic              useImm;
    } opnd_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t            ctrl_q, ctrl_d;
    opnd_t            opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              rs1_hit;
    logic              rs2_hit;
    logic              hazard;
    logic              counted;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] stored,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] r;
        r = stored;
        // r0 never forwards; EX/MEM is younger so it beats MEM/WB
        if (rs != '0) begin
            if (em_we && em_rd == rs) begin
                r = em_val;
            end else if (wb_we && wb_rd == rs) begin
                r = wb_val;
            end
        end
        return r;
    endfunction

    // Load-use: the load in EX has no data until MEM. rs2 only
    // matters when it feeds srcB or is the store data.
    always_comb begin
        rs1_hit = (ctrl_q.rd == bus.id_rs1);
        rs2_hit = (ctrl_q.rd == bus.id_rs2)
                  && (!bus.id_useImm || bus.id_memWrite);
        hazard  = bus.id_valid && ctrl_q.memRead
                  && (ctrl_q.rd != '0) && (rs1_hit || rs2_hit);
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        counted = bus.flush || hazard;

        // Bubbles keep the operand registers; only control is cleared.
        if (counted || !bus.id_valid) begin
            ctrl_d = '0;
        end else begin
            ctrl_d.aluOp    = bus.id_aluOp;
            ctrl_d.rd       = bus.id_rd;
            ctrl_d.regWrite = bus.id_regWrite;
            ctrl_d.memRead  = bus.id_memRead;
            ctrl_d.memWrite = bus.id_memWrite;
            opnd_d.rs1      = bus.id_rs1;
            opnd_d.rs2      = bus.id_rs2;
            opnd_d.regA     = bus.id_regA;
            opnd_d.regB     = bus.id_regB;
            opnd_d.imm      = bus.id_imm;
            opnd_d.useImm   = bus.id_useImm;
        end

        // flush + hazard in one cycle is still a single bubble
        if (counted && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        fwd_a = fwd(opnd_q.rs1, opnd_q.regA,
                    bus.exmem_regWrite, bus.exmem_rd, bus.exmem_result,
                    bus.memwb_regWrite, bus.memwb_rd, bus.memwb_data);
        fwd_b = fwd(opnd_q.rs2, opnd_q.regB,
                    bus.exmem_regWrite, bus.exmem_rd, bus.exmem_result,
                    bus.memwb_regWrite, bus.memwb_rd, bus.memwb_data);
    end

    assign bus.aluOp        = ctrl_q.aluOp;
    assign bus.ex_rd        = ctrl_q.rd;
    assign bus.ex_regWrite  = ctrl_q.regWrite;
    assign bus.ex_memRead   = ctrl_q.memRead;
    assign bus.ex_memWrite  = ctrl_q.memWrite;
    assign bus.srcA         = fwd_a;
    assign bus.srcB         = opnd_q.useImm ? opnd_q.imm : fwd_b;
    assign bus.ex_storeData = fwd_b;
    assign bus.stall        = hazard;
    assign bus.bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then random
// traffic, checked against a behavioural model of the stage.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) bus ();
    id_ex_stage_if #(.DATA_W(16), .REG_AW(4), .CNT_W(2))  bus2 ();

    id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        logic        flush;
        logic        id_valid;
        logic [3:0]  aluOp;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [15:0] regA;
        logic [15:0] regB;
        logic [15:0] imm;
        logic        useImm;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        exw;
        logic [3:0]  exrd;
        logic [15:0] exres;
        logic        ww;
        logic [3:0]  wrd;
        logic [15:0] wdata;
    } stim_t;

    typedef struct {
        int          id;
        logic [3:0]  aluOp;
        logic [15:0] srcA;
        logic [15:0] srcB;
        logic [15:0] st;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        stall;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t q[$];
    int   step = 0;
    int   n_total = 0;
    int   n_pass = 0;

    // Model of the instruction sitting in EX
    logic [3:0]  m_aluOp, m_rd, m_rs1, m_rs2;
    logic        m_rw, m_mr, m_mw, m_useImm;
    logic [15:0] m_regA, m_regB, m_imm;
    int          m_cnt, m_cnt2;

    task automatic model_clear();
        m_aluOp = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_useImm = 0;
        m_regA = 0; m_regB = 0; m_imm = 0;
        m_cnt = 0; m_cnt2 = 0;
    endtask

    function automatic logic [15:0] pick(input logic [3:0] rs,
                                         input logic [15:0] stored,
                                         input stim_t s);
        if (rs == 0) return stored;
        if (s.exw && s.exrd == rs) return s.exres;
        if (s.ww && s.wrd == rs) return s.wdata;
        return stored;
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        logic [15:0] b;
        e.id = 0;
        e.stall = s.id_valid && m_mr && (m_rd != 0) &&
                  ((m_rd == s.rs1) ||
                   ((m_rd == s.rs2) && (!s.useImm || s.memWrite)));
        b = pick(m_rs2, m_regB, s);
        e.srcA  = pick(m_rs1, m_regA, s);
        e.srcB  = m_useImm ? m_imm : b;
        e.st    = b;
        e.aluOp = m_aluOp;
        e.rd    = m_rd;
        e.rw    = m_rw;
        e.mr    = m_mr;
        e.mw    = m_mw;
        e.cnt   = 16'(m_cnt);
        e.cnt2  = 2'(m_cnt2);
        return e;
    endfunction

    task automatic update(input stim_t s, input logic hz);
        if (s.flush || hz) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
        end
        if (s.flush || hz || !s.id_valid) begin
            m_aluOp = 0; m_rd = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else begin
            m_aluOp = s.aluOp; m_rd = s.rd; m_rw = s.regWrite;
            m_mr = s.memRead; m_mw = s.memWrite;
            m_rs1 = s.rs1; m_rs2 = s.rs2; m_regA = s.regA;
            m_regB = s.regB; m_imm = s.imm; m_useImm = s.useImm;
        end
    endtask

    task automatic drive(input stim_t s);
        bus.flush = s.flush;          bus2.flush = s.flush;
        bus.id_valid = s.id_valid;    bus2.id_valid = s.id_valid;
        bus.id_aluOp = s.aluOp;       bus2.id_aluOp = s.aluOp;
        bus.id_rs1 = s.rs1;           bus2.id_rs1 = s.rs1;
        bus.id_rs2 = s.rs2;           bus2.id_rs2 = s.rs2;
        bus.id_rd = s.rd;             bus2.id_rd = s.rd;
        bus.id_regA = s.regA;         bus2.id_regA = s.regA;
        bus.id_regB = s.regB;         bus2.id_regB = s.regB;
        bus.id_imm = s.imm;           bus2.id_imm = s.imm;
        bus.id_useImm = s.useImm;     bus2.id_useImm = s.useImm;
        bus.id_regWrite = s.regWrite; bus2.id_regWrite = s.regWrite;
        bus.id_memRead = s.memRead;   bus2.id_memRead = s.memRead;
        bus.id_memWrite = s.memWrite; bus2.id_memWrite = s.memWrite;
        bus.exmem_regWrite = s.exw;   bus2.exmem_regWrite = s.exw;
        bus.exmem_rd = s.exrd;        bus2.exmem_rd = s.exrd;
        bus.exmem_result = s.exres;   bus2.exmem_result = s.exres;
        bus.memwb_regWrite = s.ww;    bus2.memwb_regWrite = s.ww;
        bus.memwb_rd = s.wrd;         bus2.memwb_rd = s.wrd;
        bus.memwb_data = s.wdata;     bus2.memwb_data = s.wdata;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.flush = 0; s.id_valid = 0; s.aluOp = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.regA = 0; s.regB = 0; s.imm = 0;
        s.useImm = 0; s.regWrite = 0; s.memRead = 0; s.memWrite = 0;
        s.exw = 0; s.exrd = 0; s.exres = 0;
        s.ww = 0; s.wrd = 0; s.wdata = 0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.flush    = ($urandom_range(0, 9) == 0);
        s.id_valid = ($urandom_range(0, 4) != 0);
        s.aluOp    = 4'($urandom_range(1, 15));
        s.rs1      = 4'($urandom_range(0, 5));
        s.rs2      = 4'($urandom_range(0, 5));
        s.rd       = 4'($urandom_range(0, 5));
        s.regA     = 16'($urandom);
        s.regB     = 16'($urandom);
        s.imm      = 16'($urandom);
        s.useImm   = 1'($urandom_range(0, 1));
        s.memRead  = ($urandom_range(0, 2) == 0);
        s.memWrite = !s.memRead && ($urandom_range(0, 3) == 0);
        s.regWrite = !s.memWrite && ($urandom_range(0, 3) != 0);
        s.exw      = 1'($urandom_range(0, 1));
        s.exrd     = 4'($urandom_range(0, 5));
        s.exres    = 16'($urandom);
        s.ww       = 1'($urandom_range(0, 1));
        s.wrd      = 4'($urandom_range(0, 5));
        s.wdata    = 16'($urandom);
        return s;
    endfunction

    // Drive after an edge, queue what the next negedge must show,
    // then advance the model across the following edge.
    task automatic apply(input stim_t s);
        exp_t e;
        drive(s);
        e = predict(s);
        e.id = step;
        step = step + 1;
        q.push_back(e);
        @(posedge clk);
        update(s, e.stall);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before any edge.
    task automatic apply_reset(input stim_t s);
        exp_t e;
        drive(s);
        rst_n = 1'b0;
        model_clear();
        e = predict(s);
        e.id = step;
        step = step + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [15:0] act, input logic [15:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h",
                     nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("aluOp", e.id, 16'(bus.aluOp), 16'(e.aluOp));
            chk("srcA", e.id, bus.srcA, e.srcA);
            chk("srcB", e.id, bus.srcB, e.srcB);
            chk("storeData", e.id, bus.ex_storeData, e.st);
            chk("ex_rd", e.id, 16'(bus.ex_rd), 16'(e.rd));
            chk("ex_regWrite", e.id, 16'(bus.ex_regWrite), 16'(e.rw));
            chk("ex_memRead", e.id, 16'(bus.ex_memRead), 16'(e.mr));
            chk("ex_memWrite", e.id, 16'(bus.ex_memWrite), 16'(e.mw));
            chk("stall", e.id, 16'(bus.stall), 16'(e.stall));
            chk("bubble_count", e.id, bus.bubble_count, e.cnt);
            chk("bubble_count_sat", e.id,
                16'(bus2.bubble_count), 16'(e.cnt2));
        end
    end

    initial begin
        stim_t s, f, ld, u, ai, st;
        model_clear();
        drive(idle());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        apply(idle());

        // basic pass: add r3 = r1 + r2
        s = idle();
        s.id_valid = 1; s.aluOp = 4'b0001; s.rs1 = 1; s.rs2 = 2;
        s.rd = 3; s.regA = 16'h0005; s.regB = 16'h0007; s.regWrite = 1;
        apply(s);
        apply(idle());

        // forwarding priority on r1
        s = idle();
        s.id_valid = 1; s.aluOp = 4'b0001; s.rs1 = 1; s.rs2 = 2;
        s.rd = 1; s.regA = 16'h0003; s.regB = 16'h0004; s.regWrite = 1;
        apply(s);
        f = idle();
        f.exw = 1; f.exrd = 1; f.exres = 16'h1111;
        f.ww = 1; f.wrd = 1; f.wdata = 16'h2222;
        apply(f);
        f.exw = 0;
        apply(f);
        s.rs1 = 0; s.regA = 16'h0009; s.rd = 5;
        apply(s);
        f = idle();
        f.exw = 1; f.exrd = 0; f.exres = 16'h1111;
        f.ww = 1; f.wrd = 0; f.wdata = 16'h2222;
        apply(f);

        // load-use on rs1
        ld = idle();
        ld.id_valid = 1; ld.aluOp = 4'b0001; ld.rs1 = 2; ld.rd = 4;
        ld.memRead = 1; ld.regWrite = 1; ld.regA = 16'h0100;
        ld.imm = 16'h0008; ld.useImm = 1;
        u = idle();
        u.id_valid = 1; u.aluOp = 4'b0001; u.rs1 = 4; u.rs2 = 5;
        u.rd = 6; u.regWrite = 1; u.regA = 16'h00aa; u.regB = 16'h00bb;
        apply(ld);
        apply(u);
        apply(u);
        apply(idle());

        // immediate exemption, then store still stalls
        ai = idle();
        ai.id_valid = 1; ai.aluOp = 4'b0010; ai.rs1 = 1; ai.rs2 = 4;
        ai.useImm = 1; ai.rd = 7; ai.regWrite = 1; ai.imm = 16'h0020;
        apply(ld);
        apply(ai);
        st = ai;
        st.aluOp = 4'b0001; st.memWrite = 1; st.regWrite = 0;
        st.rd = 0; st.imm = 16'h0004;
        apply(ld);
        apply(st);
        apply(st);
        apply(idle());

        // flush together with a hazard: one bubble, one count
        apply(ld);
        f = u;
        f.flush = 1;
        apply(f);
        apply(idle());

        // counter saturation on the 2-bit instance
        apply_reset(idle());
        f = idle();
        f.flush = 1;
        repeat (5) apply(f);
        apply(idle());

        // reset while stalled, then normal capture after release
        apply(ld);
        apply_reset(u);
        apply(u);
        apply(idle());

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) apply_reset(rnd());
            else apply(rnd());
        end
        apply(idle());

        @(negedge clk);
        #1;
        chk("queue_drained", step, 16'(q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
